// File: rtl/spi_cfg_sequencer.sv
// Purpose : replays a host-loaded config table to the jitter-cleaner SPI engine, interleaves single host transactions, then pulses SYNC.
// Latency : HOST_REQ seen in IDLE -> SPI_GO three cycles later; HOST_ACK lands GAP_CYCLES cycles after SPI_DONE is accepted.
// Backpressure: one SPI transaction in flight at a time; the host holds HOST_REQ until HOST_ACK; table writes are dropped during a run.
//
// Optional feature macro: SPI_SEQ_SYNC_EN. When defined, a completed table run ends with a SYNC pulse of SYNC_CYCLES cycles.
// When undefined, there is no SYNC state, SYNC is tied low and a completed run returns to IDLE straight from ARB.
//
// Ports:
//   CLK_1MHZ, RST                    : clock (rising edge), synchronous active-high reset
//   TBL_WE/TBL_ADDR/TBL_DATA         : table write port, entry = {sel[1:0], word[31:0]}
//   SEQ_LEN, START, BUSY, ERR        : table run control/status (ERR is sticky timeout flag)
//   HOST_REQ/SEL/WORD/ACK/RDATA/ERR  : single host transaction handshake
//   SPI_GO/DONE/IN/OUT/SEL           : SPI engine handshake and data
//   SYNC                             : sync request to the clock chips
module spi_cfg_sequencer #(
    parameter int DEPTH       = 32,
    parameter int GAP_CYCLES  = 4,
    parameter int TIMEOUT     = 255,
    parameter int SYNC_CYCLES = 8,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic          CLK_1MHZ,
    input  logic          RST,
    input  logic          TBL_WE,
    input  logic [AW-1:0] TBL_ADDR,
    input  logic [33:0]   TBL_DATA,
    input  logic [AW:0]   SEQ_LEN,
    input  logic          START,
    output logic          BUSY,
    output logic          ERR,
    input  logic          HOST_REQ,
    input  logic [1:0]    HOST_SEL,
    input  logic [31:0]   HOST_WORD,
    output logic          HOST_ACK,
    output logic [31:0]   HOST_RDATA,
    output logic          HOST_ERR,
    output logic          SPI_GO,
    input  logic          SPI_DONE,
    output logic [31:0]   SPI_IN,
    input  logic [31:0]   SPI_OUT,
    output logic [1:0]    SPI_SEL,
    output logic          SYNC
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_LOAD,
        S_GO,
        S_WAIT,
        S_GAP
`ifdef SPI_SEQ_SYNC_EN
        , S_SYNC
`endif
    } state_t;

    localparam int TW      = $clog2(TIMEOUT + 1);
    // GAP and SYNC never overlap, so one phase counter serves both.
    localparam int CNT_MAX = (GAP_CYCLES > SYNC_CYCLES) ? GAP_CYCLES : SYNC_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] WAIT_SAT  = TW'(TIMEOUT);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
`ifdef SPI_SEQ_SYNC_EN
    localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_CYCLES - 1);
`endif

    state_t        state_q, state_d;

    logic [33:0]   mem [DEPTH];
    logic [33:0]   ram_q;

    logic [AW:0]   len_q;
    logic [AW:0]   idx_q;
    logic          run_q;       // table run pending (spans interleaved host transactions)
    logic          host_q;      // current transaction belongs to the host
    logic          err_q;
    logic          txn_err_q;   // current transaction timed out
    logic [TW-1:0] wait_cnt_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   spi_in_q;
    logic [1:0]    spi_sel_q;
    logic [31:0]   rdata_q;

    logic done_ok;
    logic timed_out;
    logic gap_last;
    logic table_done;
`ifdef SPI_SEQ_SYNC_EN
    logic sync_last;
    assign sync_last = (state_q == S_SYNC) && (cnt_q == SYNC_LAST);
`endif

    // DONE is a level that may still be high from the previous word, so it
    // is only trusted from the second WAIT cycle on.
    assign done_ok    = (state_q == S_WAIT) && (wait_cnt_q != '0) && SPI_DONE;
    assign timed_out  = (state_q == S_WAIT) && !done_ok && (wait_cnt_q == WAIT_LAST);
    assign gap_last   = (state_q == S_GAP) && (cnt_q == GAP_LAST);
    assign table_done = (idx_q == len_q);

    // Table RAM: no reset so contents survive RST; read is always addressed
    // by idx so the word is ready one cycle after ARB, i.e. in LOAD.
    always_ff @(posedge CLK_1MHZ) begin
        if (TBL_WE && !run_q) begin
            mem[TBL_ADDR] <= TBL_DATA;
        end
        ram_q <= mem[idx_q[AW-1:0]];
    end

    always_ff @(posedge CLK_1MHZ) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (START || HOST_REQ) begin
                    state_d = S_ARB;
                end
            end
            S_ARB: begin
                if (HOST_REQ) begin
                    state_d = S_LOAD;
                end else if (run_q) begin
`ifdef SPI_SEQ_SYNC_EN
                    state_d = table_done ? S_SYNC : S_LOAD;
`else
                    state_d = table_done ? S_IDLE : S_LOAD;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: state_d = S_GO;
            S_GO:   state_d = S_WAIT;
            S_WAIT: begin
                if (done_ok || timed_out) begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_last) begin
                    if (host_q) begin
                        state_d = run_q ? S_ARB : S_IDLE;
                    end else begin
                        // A timed-out table word aborts the run, skipping SYNC.
                        state_d = txn_err_q ? S_IDLE : S_ARB;
                    end
                end
            end
`ifdef SPI_SEQ_SYNC_EN
            S_SYNC: begin
                if (sync_last) begin
                    state_d = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        SPI_GO   = (state_q == S_GO);
        BUSY     = (state_q != S_IDLE);
        HOST_ACK = gap_last && host_q;
        HOST_ERR = gap_last && host_q && txn_err_q;
`ifdef SPI_SEQ_SYNC_EN
        SYNC     = (state_q == S_SYNC);
`else
        SYNC     = 1'b0;
`endif
    end

    always_ff @(posedge CLK_1MHZ) begin
        if (RST) begin
            len_q      <= '0;
            idx_q      <= '0;
            run_q      <= 1'b0;
            host_q     <= 1'b0;
            err_q      <= 1'b0;
            txn_err_q  <= 1'b0;
            wait_cnt_q <= '0;
            cnt_q      <= '0;
            spi_in_q   <= '0;
            spi_sel_q  <= '0;
            rdata_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (START) begin
                        len_q <= SEQ_LEN;
                        idx_q <= '0;
                        err_q <= 1'b0;
                        run_q <= 1'b1;
                    end
                end
                S_ARB: begin
                    host_q <= HOST_REQ;
                    cnt_q  <= '0;
                    if (!HOST_REQ && table_done) begin
                        run_q <= 1'b0;
                    end
                end
                S_LOAD: begin
                    spi_in_q  <= host_q ? HOST_WORD : ram_q[31:0];
                    spi_sel_q <= host_q ? HOST_SEL  : ram_q[33:32];
                    txn_err_q <= 1'b0;
                end
                S_GO: begin
                    wait_cnt_q <= '0;
                end
                S_WAIT: begin
                    if (wait_cnt_q != WAIT_SAT) begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                    if (done_ok && host_q) begin
                        rdata_q <= SPI_OUT;
                    end
                    if (timed_out) begin
                        err_q     <= 1'b1;
                        txn_err_q <= 1'b1;
                    end
                    cnt_q <= '0;
                end
                S_GAP: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (gap_last && !host_q) begin
                        idx_q <= idx_q + 1'b1;
                        if (txn_err_q) begin
                            run_q <= 1'b0;
                        end
                    end
                end
`ifdef SPI_SEQ_SYNC_EN
                S_SYNC: begin
                    cnt_q <= cnt_q + 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    assign ERR        = err_q;
    assign SPI_IN     = spi_in_q;
    assign SPI_SEL    = spi_sel_q;
    assign HOST_RDATA = rdata_q;

endmodule
